// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared definitions for the 32-source round-robin mux arbiter.
//   N_SRC       : number of requesters sharing the mux
//   SEL_W       : width of a source index / mux select
//   src_idx_t   : source index type
//   arb_state_t : output-register occupancy (EMPTY / FULL)
package arb_pkg;

    localparam int N_SRC = 32;
    localparam int SEL_W = 5;

    typedef logic [SEL_W-1:0] src_idx_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux32.sv
// Plain 32:1 word multiplexer shared by the arbiter datapath.
// Ports:
//   in00..in31 : candidate words
//   s          : select (0..31)
//   y          : selected word
module mux32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in00,
    input  logic [WIDTH-1:0] in01,
    input  logic [WIDTH-1:0] in02,
    input  logic [WIDTH-1:0] in03,
    input  logic [WIDTH-1:0] in04,
    input  logic [WIDTH-1:0] in05,
    input  logic [WIDTH-1:0] in06,
    input  logic [WIDTH-1:0] in07,
    input  logic [WIDTH-1:0] in08,
    input  logic [WIDTH-1:0] in09,
    input  logic [WIDTH-1:0] in10,
    input  logic [WIDTH-1:0] in11,
    input  logic [WIDTH-1:0] in12,
    input  logic [WIDTH-1:0] in13,
    input  logic [WIDTH-1:0] in14,
    input  logic [WIDTH-1:0] in15,
    input  logic [WIDTH-1:0] in16,
    input  logic [WIDTH-1:0] in17,
    input  logic [WIDTH-1:0] in18,
    input  logic [WIDTH-1:0] in19,
    input  logic [WIDTH-1:0] in20,
    input  logic [WIDTH-1:0] in21,
    input  logic [WIDTH-1:0] in22,
    input  logic [WIDTH-1:0] in23,
    input  logic [WIDTH-1:0] in24,
    input  logic [WIDTH-1:0] in25,
    input  logic [WIDTH-1:0] in26,
    input  logic [WIDTH-1:0] in27,
    input  logic [WIDTH-1:0] in28,
    input  logic [WIDTH-1:0] in29,
    input  logic [WIDTH-1:0] in30,
    input  logic [WIDTH-1:0] in31,
    input  logic [4:0]       s,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (s)
            5'd0:  y = in00;
            5'd1:  y = in01;
            5'd2:  y = in02;
            5'd3:  y = in03;
            5'd4:  y = in04;
            5'd5:  y = in05;
            5'd6:  y = in06;
            5'd7:  y = in07;
            5'd8:  y = in08;
            5'd9:  y = in09;
            5'd10: y = in10;
            5'd11: y = in11;
            5'd12: y = in12;
            5'd13: y = in13;
            5'd14: y = in14;
            5'd15: y = in15;
            5'd16: y = in16;
            5'd17: y = in17;
            5'd18: y = in18;
            5'd19: y = in19;
            5'd20: y = in20;
            5'd21: y = in21;
            5'd22: y = in22;
            5'd23: y = in23;
            5'd24: y = in24;
            5'd25: y = in25;
            5'd26: y = in26;
            5'd27: y = in27;
            5'd28: y = in28;
            5'd29: y = in29;
            5'd30: y = in30;
            5'd31: y = in31;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux32_rr_arbiter_pick.sv
// Combinational rotate-priority picker (rr_pick32).
// Ports:
//   req_i   : request vector
//   last_i  : most recently served index (gets lowest priority)
//   found_o : at least one request is present
//   idx_o   : winning index, or last_i when nothing is requested
module rr_pick32
    import arb_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    input  src_idx_t         last_i,
    output logic             found_o,
    output src_idx_t         idx_o
);

    logic [SEL_W:0]       shift;
    logic [2*N_SRC-1:0]   dbl;
    logic [N_SRC-1:0]     rot;
    src_idx_t             off;

    // Rotate so that bit 0 of rot is source (last+1). The shift ranges
    // 1..32, so a concatenated copy makes the rotation a plain shift.
    assign shift = {1'b0, last_i} + (SEL_W+1)'(1);
    assign dbl   = {req_i, req_i} >> shift;
    assign rot   = dbl[N_SRC-1:0];

    // Find-first from the low end; scanning downward leaves the lowest hit.
    always_comb begin
        found_o = 1'b0;
        off     = '0;
        for (int j = N_SRC-1; j >= 0; j--) begin
            if (rot[j]) begin
                found_o = 1'b1;
                off     = src_idx_t'(j);
            end
        end
    end

    // Undo the rotation; 5-bit arithmetic gives the mod-32 wrap for free.
    assign idx_o = found_o ? src_idx_t'(last_i + off + src_idx_t'(1)) : last_i;

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter sharing one mux32 among 32 sources, with a
// single-entry registered output and valid/ready handshake.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req               : per-source request (level)
//   in00..in31        : source words
//   grant             : one-hot, combinational; source captured at this edge
//   select            : mux select (winner, or last when idle)
//   out_data/out_src  : captured word and its source index
//   out_valid         : output holds an unconsumed word
//   out_ready         : consumer accepts the word this cycle
module mux32_rr_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      req,
    input  logic [WIDTH-1:0] in00,
    input  logic [WIDTH-1:0] in01,
    input  logic [WIDTH-1:0] in02,
    input  logic [WIDTH-1:0] in03,
    input  logic [WIDTH-1:0] in04,
    input  logic [WIDTH-1:0] in05,
    input  logic [WIDTH-1:0] in06,
    input  logic [WIDTH-1:0] in07,
    input  logic [WIDTH-1:0] in08,
    input  logic [WIDTH-1:0] in09,
    input  logic [WIDTH-1:0] in10,
    input  logic [WIDTH-1:0] in11,
    input  logic [WIDTH-1:0] in12,
    input  logic [WIDTH-1:0] in13,
    input  logic [WIDTH-1:0] in14,
    input  logic [WIDTH-1:0] in15,
    input  logic [WIDTH-1:0] in16,
    input  logic [WIDTH-1:0] in17,
    input  logic [WIDTH-1:0] in18,
    input  logic [WIDTH-1:0] in19,
    input  logic [WIDTH-1:0] in20,
    input  logic [WIDTH-1:0] in21,
    input  logic [WIDTH-1:0] in22,
    input  logic [WIDTH-1:0] in23,
    input  logic [WIDTH-1:0] in24,
    input  logic [WIDTH-1:0] in25,
    input  logic [WIDTH-1:0] in26,
    input  logic [WIDTH-1:0] in27,
    input  logic [WIDTH-1:0] in28,
    input  logic [WIDTH-1:0] in29,
    input  logic [WIDTH-1:0] in30,
    input  logic [WIDTH-1:0] in31,
    output logic [31:0]      grant,
    output logic [4:0]       select,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    arb_state_t       state_q, state_d;
    src_idx_t         last_q, last_d;
    src_idx_t         src_q, src_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             found;
    src_idx_t         win_idx;
    logic             load;
    logic [WIDTH-1:0] mux_y;

    rr_pick32 u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .found_o (found),
        .idx_o   (win_idx)
    );

    assign select = win_idx;

    mux32 #(.WIDTH(WIDTH)) u_mux (
        .in00 (in00), .in01 (in01), .in02 (in02), .in03 (in03),
        .in04 (in04), .in05 (in05), .in06 (in06), .in07 (in07),
        .in08 (in08), .in09 (in09), .in10 (in10), .in11 (in11),
        .in12 (in12), .in13 (in13), .in14 (in14), .in15 (in15),
        .in16 (in16), .in17 (in17), .in18 (in18), .in19 (in19),
        .in20 (in20), .in21 (in21), .in22 (in22), .in23 (in23),
        .in24 (in24), .in25 (in25), .in26 (in26), .in27 (in27),
        .in28 (in28), .in29 (in29), .in30 (in30), .in31 (in31),
        .s    (select),
        .y    (mux_y)
    );

    // A word can be taken when the register is free or is being drained.
    assign load = found && ((state_q == EMPTY) || out_ready);

    // Grant is suppressed during reset so no requester believes its word
    // was consumed while the registers are being cleared.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_grant
        assign grant[gi] = load && !rst && (win_idx == src_idx_t'(gi));
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        src_d   = src_q;
        data_d  = data_q;
        if (load) begin
            state_d = FULL;
            last_d  = win_idx;
            src_d   = win_idx;
            data_d  = mux_y;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            last_q  <= src_idx_t'(N_SRC-1);
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_src   = src_q;
    assign out_data  = data_q;

endmodule
